// File: rtl/encoder_stream_arbiter.sv
// encoder_stream_arbiter
// Packet-granular round-robin arbiter sharing one payload encoder between NUM_SRC
// AXI-Stream sources. Whole packets (first beat through tlast) are forwarded from the
// granted source through a registered main/skid output stage.
// Optional build macro: ENCODER_STREAM_ARB_SRC_TAG_EN -- when defined, m_axis_tuser carries
// the granted source index instead of the source's own tuser.
module encoder_stream_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NUM_SRC*64-1:0] s_axis_tdata,
  input  logic [NUM_SRC*8-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC*8-1:0]  s_axis_tuser,
  input  logic [NUM_SRC*8-1:0]  s_axis_tdest,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  input  logic [NUM_SRC-1:0]    src_en,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic [7:0]            m_axis_tuser,
  output logic [7:0]            m_axis_tdest,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy
);

  // Packed beat: {tdata, tkeep, tuser, tdest, tlast}
  localparam int unsigned BeatW = 64 + 8 + 8 + 8 + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic [NUM_SRC-1:0] req;

  logic [63:0] sel_tdata;
  logic [7:0]  sel_tkeep;
  logic [7:0]  sel_tuser;
  logic [7:0]  sel_tdest;
  logic        sel_tlast;
  logic        sel_tvalid;
  logic [7:0]  in_user;
  logic [BeatW-1:0] in_beat;
  logic        accept;

  logic [BeatW-1:0] main_q;
  logic [BeatW-1:0] skid_q;
  logic             main_valid_q;
  logic             skid_full_q;

  assign req = s_axis_tvalid & src_en;

  // Round-robin search upward from the source after the last grant, wrapping.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    pick    = grant_q;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(grant_q) + k) % NUM_SRC;
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = IDX_W'(cand);
      end
    end
  end

  // Steer the granted source's beat fields.
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    sel_tdest  = '0;
    sel_tlast  = 1'b0;
    sel_tvalid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_tdata  = s_axis_tdata[i*64 +: 64];
        sel_tkeep  = s_axis_tkeep[i*8 +: 8];
        sel_tuser  = s_axis_tuser[i*8 +: 8];
        sel_tdest  = s_axis_tdest[i*8 +: 8];
        sel_tlast  = s_axis_tlast[i];
        sel_tvalid = s_axis_tvalid[i];
      end
    end
  end

`ifdef ENCODER_STREAM_ARB_SRC_TAG_EN
  // Tag beats with their originating source so the encoder header can identify it.
  assign in_user = 8'(grant_q);
`else
  assign in_user = sel_tuser;
`endif

  assign in_beat = {sel_tdata, sel_tkeep, in_user, sel_tdest, sel_tlast};

  // Ready is gated only by registered state, so accept needs no combinational path from
  // m_axis_tready.
  assign accept = (state_q == StBusy) && sel_tvalid && !skid_full_q;

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state: grant on any request, release after the tlast beat is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StBusy;
      StBusy:  if (accept && sel_tlast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: only the granted source ever sees ready.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == StBusy && !skid_full_q) s_axis_tready[grant_q] = 1'b1;
    busy = (state_q == StBusy);
  end

  // Grant register; reset value makes source 0 the first winner.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_q <= IDX_W'(NUM_SRC - 1);
    end else if (state_q == StIdle && any_req) begin
      grant_q <= pick;
    end
  end

  // Two-entry output stage: main drives m_axis, skid absorbs one beat while main stalls.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_full_q  <= 1'b0;
    end else if (!main_valid_q || m_axis_tready) begin
      if (skid_full_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        if (accept) skid_q <= in_beat;
        skid_full_q  <= accept;
      end else begin
        if (accept) main_q <= in_beat;
        main_valid_q <= accept;
      end
    end else if (accept) begin
      skid_q      <= in_beat;
      skid_full_q <= 1'b1;
    end
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tdest, m_axis_tlast} = main_q;
  assign m_axis_tvalid = main_valid_q;
  assign grant_idx     = grant_q;

endmodule

// File: tb/tb_encoder_stream_arbiter.sv
// Scoreboard bench for encoder_stream_arbiter: per-source packet queues feed the DUT,
// a round-robin packet-order model fills the expected-beat queue, and a monitor checks
// every m_axis beat against it.
module tb_encoder_stream_arbiter;
  localparam int NS = 4;
  localparam int IW = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [NS*64-1:0]  s_axis_tdata  = '0;
  logic [NS*8-1:0]   s_axis_tkeep  = '0;
  logic [NS*8-1:0]   s_axis_tuser  = '0;
  logic [NS*8-1:0]   s_axis_tdest  = '0;
  logic [NS-1:0]     s_axis_tlast  = '0;
  logic [NS-1:0]     s_axis_tvalid = '0;
  logic [NS-1:0]     s_axis_tready;
  logic [NS-1:0]     src_en = '1;
  logic [63:0]       m_axis_tdata;
  logic [7:0]        m_axis_tkeep;
  logic [7:0]        m_axis_tuser;
  logic [7:0]        m_axis_tdest;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [IW-1:0]     grant_idx;
  logic              busy;

  encoder_stream_arbiter #(.NUM_SRC(NS), .IDX_W(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tdest(s_axis_tdest), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .src_en(src_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tdest(m_axis_tdest), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  user;
    logic [7:0]  dest;
    logic        last;
    logic        first;
  } beat_t;

  beat_t src_q[NS][$];    // beats still to be offered by each source
  beat_t exp_src[NS][$];  // expected output beats per source, not yet ordered
  beat_t sb[$];           // expected m_axis beats in order
  int    in_order[$];     // expected packet order on the input side

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int model_last = NS - 1;
  int rdy_mode = 0;
  bit bub_en = 0;
  int in_fired = 0;
  logic [NS-1:0] fire = '0;
  bit skid_chk_pending = 0;
  bit lat_arm = 0;
  int rec_in = -1, rec_out = -1, last_out = -1;
  bit gap_chk = 0;
  int prev_out_cyc = -1;
  bit prev_last = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add_pkt(input int s, input int len, input logic [7:0] klast,
                         input logic [7:0] usr);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = {$urandom(), $urandom()};
      b.keep  = (k == len - 1) ? klast : 8'hff;
      b.user  = usr;
      b.dest  = 8'($urandom());
      b.last  = (k == len - 1);
      b.first = (k == 0);
      src_q[s].push_back(b);
`ifdef ENCODER_STREAM_ARB_SRC_TAG_EN
      b.user = 8'(s);
`endif
      exp_src[s].push_back(b);
    end
  endtask

  // Round-robin over whole pending packets among enabled sources.
  task automatic schedule(input logic [NS-1:0] en);
    int cnt[NS];
    bit found;
    int pick;
    beat_t e;
    for (int s = 0; s < NS; s++) begin
      cnt[s] = 0;
      foreach (exp_src[s][j]) if (exp_src[s][j].last) cnt[s]++;
    end
    do begin
      found = 0;
      pick  = 0;
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (model_last + k) % NS;
        if (!found && en[s] && cnt[s] > 0) begin
          found = 1;
          pick  = s;
        end
      end
      if (found) begin
        cnt[pick]--;
        model_last = pick;
        in_order.push_back(pick);
        do begin
          e = exp_src[pick].pop_front();
          sb.push_back(e);
        end while (!e.last);
      end
    end while (found);
  endtask

  task automatic flush();
    sb.delete();
    in_order.delete();
    for (int s = 0; s < NS; s++) begin
      src_q[s].delete();
      exp_src[s].delete();
    end
    fire = '0;
    skid_chk_pending = 0;
    model_last = NS - 1;
  endtask

  task automatic do_reset();
    @(negedge clk_in); #2;
    rst_in = 1'b1;
    flush();
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || in_order.size() != 0) && n < budget) begin
      @(negedge clk_in); #2;
      n++;
    end
    chk("drain", 64'(sb.size() + in_order.size()), 64'd0);
  endtask

  // Source driver: presents queued beats at negedge, samples handshakes just before posedge.
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      for (int i = 0; i < NS; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      fire = '0;
      for (int i = 0; i < NS; i++) begin
        if (!rst_in && src_q[i].size() > 0) begin
          s_axis_tdata[i*64 +: 64] = src_q[i][0].data;
          s_axis_tkeep[i*8 +: 8]   = src_q[i][0].keep;
          s_axis_tuser[i*8 +: 8]   = src_q[i][0].user;
          s_axis_tdest[i*8 +: 8]   = src_q[i][0].dest;
          s_axis_tlast[i]          = src_q[i][0].last;
          s_axis_tvalid[i] = !(bub_en && !src_q[i][0].first && $urandom_range(0, 3) == 0);
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
      case (rdy_mode)
        1:       m_axis_tready = ($urandom_range(0, 9) < 7);
        2:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_axis_tready = 1'b1;
      endcase
      if (lat_arm && rec_in < 0 && |s_axis_tvalid) rec_in = cyc;
      #4;
      if (!rst_in) begin
        logic [NS-1:0] mask;
        mask = '0;
        if (in_order.size() > 0) mask[in_order[0]] = 1'b1;
        chk("tready_excl", 64'(s_axis_tready & ~mask), 64'd0);
        if (skid_chk_pending) chk("skid_backpressure", 64'(s_axis_tready), 64'd0);
        fire = s_axis_tvalid & s_axis_tready;
        skid_chk_pending = m_axis_tvalid && !m_axis_tready && (|fire);
        for (int i = 0; i < NS; i++) begin
          if (fire[i] && src_q[i].size() > 0) begin
            in_fired++;
            if (src_q[i][0].last && in_order.size() > 0 && in_order[0] == i)
              void'(in_order.pop_front());
          end
        end
      end else begin
        fire = '0;
        skid_chk_pending = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every m_axis handshake.
  initial begin
    bit stall_prev;
    logic [88:0] held;
    beat_t e;
    stall_prev = 0;
    held = '0;
    forever begin
      @(negedge clk_in); #4;
      if (rst_in) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
          chk("hold_data", m_axis_tdata, held[88:25]);
          chk("hold_side", {40'd0, m_axis_tkeep, m_axis_tuser, m_axis_tdest},
              {40'd0, held[24:1]});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            chk("tdata", m_axis_tdata, e.data);
            chk("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
            chk("tuser", 64'(m_axis_tuser), 64'(e.user));
            chk("tdest", 64'(m_axis_tdest), 64'(e.dest));
            chk("tlast", 64'(m_axis_tlast), 64'(e.last));
          end
          if (lat_arm) begin
            if (rec_out < 0) rec_out = cyc;
            last_out = cyc;
          end
          if (gap_chk) begin
            if (prev_out_cyc >= 0)
              chk("beat_spacing", 64'(cyc - prev_out_cyc), prev_last ? 64'd2 : 64'd1);
            prev_out_cyc = cyc;
            prev_last = m_axis_tlast;
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        held = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tdest, m_axis_tlast};
      end
    end
  end

  initial begin
    int base;
    int n;
    // Reset state
    #12;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tdata", m_axis_tdata, 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'(NS - 1));
    chk("rst_busy", 64'(busy), 64'd0);
    #3 rst_in = 1'b0;

    // Single source 0, 3 beats: latency and back-to-back output
    do_reset();
    lat_arm = 1;
    add_pkt(0, 3, 8'hf0, 8'h11);
    schedule('1);
    wait_drain(200);
    chk("first_beat_latency", 64'(rec_out - rec_in), 64'd2);
    chk("pkt_span", 64'(last_out - rec_out), 64'd2);
    chk("grant_after_p1", 64'(grant_idx), 64'd0);
    lat_arm = 0;

    // Sources 0, 1, 3 with two 2-beat packets each: rotation and one-cycle gap
    do_reset();
    gap_chk = 1;
    prev_out_cyc = -1;
    for (int r = 0; r < 2; r++) begin
      add_pkt(0, 2, 8'hff, 8'h20);
      add_pkt(1, 2, 8'h0f, 8'h21);
      add_pkt(3, 2, 8'h3f, 8'h23);
    end
    schedule('1);
    wait_drain(300);
    gap_chk = 0;
    chk("grant_after_p2", 64'(grant_idx), 64'd3);

    // 6-beat packet with encoder ready pattern 1,0,0,1
    do_reset();
    rdy_mode = 2;
    add_pkt(0, 6, 8'h7f, 8'h30);
    schedule('1);
    wait_drain(300);
    rdy_mode = 0;

    // src_en for source 1 cleared mid-packet
    do_reset();
    add_pkt(1, 4, 8'h01, 8'h41);
    schedule('1);
    base = in_fired;
    n = 0;
    while (in_fired < base + 1 && n < 100) begin
      @(negedge clk_in); #2;
      n++;
    end
    src_en = 4'b1101;
    add_pkt(0, 2, 8'hff, 8'h40);
    add_pkt(1, 3, 8'hff, 8'h42);
    schedule(4'b1101);
    wait_drain(300);
    repeat (10) @(negedge clk_in);
    chk("disabled_grant", 64'(grant_idx), 64'd0);
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("src1_starved", 64'(src_q[1].size()), 64'd3);
    src_en = '1;

    // Asynchronous reset mid-packet, then 0 beats 2 on restart
    do_reset();
    add_pkt(3, 6, 8'hff, 8'h53);
    schedule('1);
    base = in_fired;
    n = 0;
    while (in_fired < base + 2 && n < 100) begin
      @(negedge clk_in); #2;
      n++;
    end
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_in = 1'b1;
    flush();
    #1;
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_grant", 64'(grant_idx), 64'(NS - 1));
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b0;
    add_pkt(0, 2, 8'hff, 8'h50);
    add_pkt(2, 2, 8'hff, 8'h52);
    schedule('1);
    wait_drain(300);
    chk("grant_after_p5", 64'(grant_idx), 64'd2);

    // Source 2 with tuser A5
    do_reset();
    add_pkt(2, 2, 8'hff, 8'hA5);
    schedule('1);
    wait_drain(200);

    // Randomized rounds: random packets, encoder backpressure, mid-packet bubbles
    rdy_mode = 1;
    bub_en = 1;
    for (int r = 0; r < 40; r++) begin
      for (int s = 0; s < NS; s++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++)
          add_pkt(s, $urandom_range(1, 5), 8'($urandom_range(1, 255)), 8'($urandom()));
      end
      schedule('1);
      wait_drain(3000);
    end
    rdy_mode = 0;
    bub_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
